// File: rtl/ramp_seq_pkg.sv
// Shared types and constants for the ramp sequencer: FSM states, step codes
// and the step lookup.
package ramp_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DWELL = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] Y_ZERO    = 2'b00;
    localparam logic [1:0] Y_ONE     = 2'b01;
    localparam logic [1:0] Y_SIXTEEN = 2'b10;
    localparam logic [1:0] Y_BIG     = 2'b11;

    localparam logic [11:0] STEP_ZERO    = 12'd0;
    localparam logic [11:0] STEP_ONE     = 12'd1;
    localparam logic [11:0] STEP_SIXTEEN = 12'd16;
    localparam logic [11:0] STEP_BIG     = 12'd1290;

    localparam logic [11:0] DATA_MAX = 12'hFFF;

    function automatic logic [11:0] step_of(input logic [1:0] y);
        case (y)
            Y_ONE:     return STEP_ONE;
            Y_SIXTEEN: return STEP_SIXTEEN;
            Y_BIG:     return STEP_BIG;
            default:   return STEP_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/ramp_seq_tick.sv
// Delta prescaler: counts 0..eff_div-1 while not cleared, tick on the last count.
// A divider of 0 behaves as 1 (tick every cycle).
module ramp_seq_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    assign last = (div == '0) ? '0 : div - 1'b1;
    assign tick = !clr && (cnt == last);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/ramp_seq_ctrl.sv
// Ramp sweep sequencer: single-shot or continuous sweeps with top dwell, never
// letting the ramp wrap. RAMP_SEQ_SWEEP_CNT_EN adds a saturating sweep counter.
module ramp_seq_ctrl
    import ramp_seq_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DWELL_W = 16,
    parameter int DATA_W  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [1:0]         y_sel,
    input  logic [DIV_W-1:0]   tick_div,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         ramp_y,
    output logic               ramp_enb,
    output logic               ramp_delta,
    output logic [DATA_W-1:0]  shadow,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef RAMP_SEQ_SWEEP_CNT_EN
    ,
    output logic [15:0]        sweep_cnt
`endif
);

    state_t             state, state_nxt;
    logic               cont_q;
    logic [1:0]         y_q;
    logic [DIV_W-1:0]   div_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               tick;
    logic               start_ok;
    logic               reject;
    logic               sweep_end;
    logic [DATA_W:0]    nxt;

    ramp_seq_tick #(.DIV_W(DIV_W)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != RUN),
        .div  (div_q),
        .tick (tick)
    );

    // One extra bit so a step past the top shows up as a carry instead of a wrap.
    assign nxt = {1'b0, shadow} + (DATA_W+1)'(step_of(y_q));

    always_comb begin
        state_nxt  = state;
        ramp_delta = 1'b0;
        sweep_end  = 1'b0;
        start_ok   = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (y_sel != Y_ZERO) begin
                        start_ok  = 1'b1;
                        state_nxt = CLEAR;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            CLEAR: state_nxt = RUN;
            RUN: begin
                if (tick) begin
                    if (!nxt[DATA_W]) begin
                        ramp_delta = 1'b1;
                    end else if (dwell_q == '0) begin
                        sweep_end = 1'b1;
                        state_nxt = cont_q ? CLEAR : DONE;
                    end else begin
                        state_nxt = DWELL;
                    end
                end
            end
            DWELL: begin
                if (dwell_cnt == dwell_q - 1'b1) begin
                    sweep_end = 1'b1;
                    state_nxt = cont_q ? CLEAR : DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort beats everything, including a delta due this cycle.
        if (stop && state != IDLE) begin
            state_nxt  = IDLE;
            ramp_delta = 1'b0;
            sweep_end  = 1'b0;
        end
    end

    assign busy     = (state != IDLE);
    assign ramp_enb = (state == RUN) || (state == DWELL);
    assign done     = (state == DONE);
    assign ramp_y   = busy ? y_q : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cont_q    <= 1'b0;
            y_q       <= 2'b00;
            div_q     <= '0;
            dwell_q   <= '0;
            dwell_cnt <= '0;
            shadow    <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= reject;
            if (start_ok) begin
                cont_q  <= continuous;
                y_q     <= y_sel;
                div_q   <= tick_div;
                dwell_q <= dwell;
            end
            if (state == CLEAR)
                shadow <= '0;
            else if (ramp_delta)
                shadow <= nxt[DATA_W-1:0];
            dwell_cnt <= (state == DWELL) ? dwell_cnt + 1'b1 : '0;
        end
    end

`ifdef RAMP_SEQ_SWEEP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok)
            sweep_cnt <= '0;
        else if (sweep_end && sweep_cnt != 16'hFFFF)
            sweep_cnt <= sweep_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_ramp_seq_ctrl.sv
// Directed bench for ramp_seq_ctrl: timing of deltas, sweep lengths, dwell,
// continuous restarts, reject/abort/reset behaviour.
module tb_ramp_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, stop, continuous;
    logic [1:0]  y_sel;
    logic [15:0] tick_div, dwell;
    logic [1:0]  ramp_y;
    logic        ramp_enb, ramp_delta, busy, done, err;
    logic [11:0] shadow;
`ifdef RAMP_SEQ_SWEEP_CNT_EN
    logic [15:0] sweep_cnt;
`endif

    int pass_cnt = 0;
    int total    = 0;

    ramp_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .y_sel      (y_sel),
        .tick_div   (tick_div),
        .dwell      (dwell),
        .ramp_y     (ramp_y),
        .ramp_enb   (ramp_enb),
        .ramp_delta (ramp_delta),
        .shadow     (shadow),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef RAMP_SEQ_SWEEP_CNT_EN
        ,
        .sweep_cnt  (sweep_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a start; returns in the CLEAR cycle (cycle 0 of the sweep).
    task automatic start_sweep(input logic [1:0] y, input logic [15:0] dv,
                               input logic [15:0] dw, input logic cont);
        y_sel = y; tick_div = dv; dwell = dw; continuous = cont; start = 1'b1;
        step();
        start = 1'b0;
        chk("clear_busy", 32'(busy), 1);
        chk("clear_enb", 32'(ramp_enb), 0);
    endtask

    initial begin
        int n_delta, done_cyc, n_clr, n_done;
        logic wrap;
        logic [11:0] prev;

        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        y_sel = 2'b00; tick_div = 16'd0; dwell = 16'd0;
        step(); step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_enb", 32'(ramp_enb), 0);
        chk("rst_delta", 32'(ramp_delta), 0);
        chk("rst_shadow", 32'(shadow), 0);
        chk("rst_y", 32'(ramp_y), 0);
        chk("rst_done_err", 32'({done, err}), 0);
        rst = 1'b0;
        step();

        // y=11, div 4, dwell 2, single-shot; a start with y=01 lands mid-RUN
        start_sweep(2'b11, 16'd4, 16'd2, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step();
            chk($sformatf("t1_delta_c%0d", i), 32'(ramp_delta), 32'(i == 4 || i == 8 || i == 12));
            chk($sformatf("t1_shadow_c%0d", i), 32'(shadow),
                (i > 12) ? 3870 : (i > 8) ? 2580 : (i > 4) ? 1290 : 0);
            chk($sformatf("t1_done_c%0d", i), 32'(done), 32'(i == 19));
            chk($sformatf("t1_busy_c%0d", i), 32'(busy), 32'(i <= 19));
            chk($sformatf("t1_enb_c%0d", i), 32'(ramp_enb), 32'(i <= 18));
            chk($sformatf("t1_y_c%0d", i), 32'(ramp_y), (i <= 19) ? 3 : 0);
            if (i == 5) begin start = 1'b1; y_sel = 2'b01; end
            if (i == 6) start = 1'b0;
        end

        // y=01, div 0 (as 1), dwell 0, single-shot: full 4095-delta sweep
        start_sweep(2'b01, 16'd0, 16'd0, 1'b0);
        n_delta = 0; done_cyc = 0; wrap = 1'b0; prev = 12'd0;
        for (int i = 1; i <= 4200; i++) begin
            step();
            if (ramp_delta) n_delta++;
            if (shadow < prev) wrap = 1'b1;
            prev = shadow;
            if (i == 4095) chk("t2_delta_last", 32'(ramp_delta), 1);
            if (i == 4096) begin
                chk("t2_no_delta_top", 32'(ramp_delta), 0);
                chk("t2_shadow_top", 32'(shadow), 4095);
            end
            if (done && done_cyc == 0) done_cyc = i;
            if (!busy) break;
        end
        chk("t2_deltas", 32'(n_delta), 4095);
        chk("t2_done_cyc", 32'(done_cyc), 4097);
        chk("t2_no_wrap", 32'(wrap), 0);
        chk("t2_idle", 32'(busy), 0);

        // y=10, div 1, dwell 0, continuous: 3 sweeps of 255 deltas, ignored restart
        start_sweep(2'b10, 16'd1, 16'd0, 1'b1);
        n_delta = 0; n_clr = 0; n_done = 0;
        for (int i = 1; i <= 771; i++) begin
            step();
            if (ramp_delta) n_delta++;
            if (busy && !ramp_enb) n_clr++;
            if (done) n_done++;
            if (i == 256) chk("t3_shadow_top", 32'(shadow), 4080);
            if (i == 258) chk("t3_shadow_cleared", 32'(shadow), 0);
`ifdef RAMP_SEQ_SWEEP_CNT_EN
            if (i == 257) chk("t3_sweep_cnt1", 32'(sweep_cnt), 1);
            if (i == 771) chk("t3_sweep_cnt3", 32'(sweep_cnt), 3);
`endif
            if (i == 100) begin start = 1'b1; y_sel = 2'b11; end
            if (i == 101) start = 1'b0;
        end
        chk("t3_deltas", 32'(n_delta), 765);
        chk("t3_clears", 32'(n_clr), 3);
        chk("t3_no_done", 32'(n_done), 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t3_stop_idle", 32'(busy), 0);
        chk("t3_stop_nodone", 32'(done), 0);

        // start with y=00 is rejected; start+stop together does nothing
        y_sel = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_err", 32'(err), 1);
        chk("t4_err_busy", 32'(busy), 0);
        step();
        chk("t4_err_pulse", 32'(err), 0);
        y_sel = 2'b11; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("t4_ss_busy", 32'(busy), 0);
        chk("t4_ss_err", 32'(err), 0);

        // stop mid-RUN after two deltas (a third is due that very cycle)
        start_sweep(2'b11, 16'd1, 16'd0, 1'b0);
        step(); step(); step();
        chk("t5_shadow_pre", 32'(shadow), 2580);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_enb", 32'(ramp_enb), 0);
        chk("t5_shadow_hold", 32'(shadow), 2580);
        chk("t5_done", 32'(done), 0);
        step();
        chk("t5_done_after", 32'(done), 0);

        // reset while dwelling
        start_sweep(2'b11, 16'd1, 16'd100, 1'b0);
        for (int i = 1; i <= 10; i++) step();
        chk("t6_dwell_enb", 32'(ramp_enb), 1);
        chk("t6_dwell_delta", 32'(ramp_delta), 0);
        chk("t6_dwell_shadow", 32'(shadow), 3870);
        rst = 1'b1;
        step();
        chk("t6_rst_outs", 32'({ramp_y, ramp_enb, ramp_delta, busy, done, err}), 0);
        chk("t6_rst_shadow", 32'(shadow), 0);
`ifdef RAMP_SEQ_SWEEP_CNT_EN
        chk("t6_rst_sweep_cnt", 32'(sweep_cnt), 0);
`endif
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/ramp_seq_ctrl.md
Name: ramp_seq_ctrl

Overview:
- Sequencer for the 12-bit ramp counter datapath. Drives the ramp's step select (Y), enable and delta strobe.
- Runs single-shot or continuous sweeps from 0 toward 4095 at a programmable tick rate. Holds a programmable dwell at the top of each sweep.
- Keeps an internal shadow of the ramp value, so it never lets the ramp wrap past 4095.
- Sits between the pattern-control registers and the ramp instance.

Parameters:
- DIV_W, 16, width of the tick divider (clock cycles per delta).
- DWELL_W, 16, width of the top-of-sweep dwell counter.
- DATA_W, 12, ramp data width; top value is 2^DATA_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle start request
- stop  in  1  single-cycle abort request
- continuous  in  1  1 = restart sweep after dwell; 0 = single-shot
- y_sel  in  2  step code: 00=0, 01=1, 10=16, 11=1290
- tick_div  in  DIV_W  cycles between deltas; 0 is treated as 1
- dwell  in  DWELL_W  cycles held at top before done/restart
- ramp_y  out  2  step code to ramp
- ramp_enb  out  1  ramp enable; low clears the ramp to 0
- ramp_delta  out  1  one-cycle add strobe to ramp
- shadow  out  DATA_W  controller's copy of the ramp value
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a single-shot sweep completes
- err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; all outputs 0, including ramp_y, shadow and counters.
- Config capture: continuous, y_sel, tick_div and dwell are latched only when start is accepted in IDLE. Input changes while busy are ignored.
- IDLE:
  - ramp_enb=0, ramp_delta=0.
  - start with y_sel!=00 -> CLEAR.
  - start with y_sel==00 -> err=1 for one cycle; stay IDLE.
  - start and stop in the same cycle: stop wins, start is ignored, no err.
- CLEAR (1 cycle): ramp_enb=0, shadow<=0, prescaler<=0 -> RUN.
- RUN:
  - ramp_enb=1; prescaler counts 0..eff_div-1, where eff_div=max(tick_div,1).
  - At prescaler==eff_div-1, evaluate next = shadow + step, using DATA_W+1-bit arithmetic.
  - If next <= 2^DATA_W-1: ramp_delta=1 that cycle, shadow<=next, prescaler<=0.
  - Otherwise: no delta; go to DWELL with dwell counter cleared.
- DWELL:
  - ramp_enb=1, no deltas; counts dwell cycles (dwell=0 means zero cycles).
  - On exit, single-shot -> DONE; continuous -> CLEAR.
- DONE (1 cycle): done=1 -> IDLE. The ramp clears in IDLE.
- stop: in any busy state, next state is IDLE; no done pulse; shadow holds its value until the next CLEAR.
- start while busy: ignored.
- Sweep length (deltas per sweep):
  - y=01: 4095 deltas, top 4095.
  - y=10: 255 deltas, top 4080.
  - y=11: 3 deltas, top 3870.
- Timing: first delta is eff_div cycles after the CLEAR cycle; deltas are then spaced exactly eff_div cycles apart. With eff_div=1, deltas occur on back-to-back cycles.
- ramp_y holds the latched y_sel whenever busy, and 00 in IDLE.
- Invariant: shadow equals the ramp output one cycle after each delta.

Optional Feature:
- Macro: RAMP_SEQ_SWEEP_CNT_EN.
- Defined:
  - Adds output port sweep_cnt [15:0].
  - Increments on each DWELL exit (completed sweep) and saturates at 65535.
  - Clears on reset and on start accept.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- ramp_seq_pkg:
  - state enum (IDLE, CLEAR, RUN, DWELL, DONE)
  - Y code constants
  - step constants 0/1/16/1290
  - step lookup function (y code -> 12-bit step)
  - DATA_MAX constant
- Sub-module ramp_seq_tick: prescaler with clear input, eff_div handling and a tick output; instantiated once.

Test Plan:
- y=11, tick_div=4, dwell=2, single: delta at CLEAR+4, +8, +12; shadow 1290/2580/3870; no 4th delta; DWELL 2 cycles; done pulses once; busy falls the cycle after done.
- y=01, tick_div=0, single: delta on every RUN cycle; exactly 4095 deltas; shadow ends at 4095; shadow never wraps.
- y=10, tick_div=1, dwell=0, continuous=1: 255 deltas per sweep (top 4080); CLEAR every sweep (ramp_enb low 1 cycle); no done; with macro, sweep_cnt reaches 3 after 3 sweeps.
- start with y=00 -> err one cycle, busy stays 0. start+stop same cycle in IDLE -> nothing happens.
- stop mid-RUN after 2 deltas (y=11) -> IDLE next cycle, ramp_enb=0, no done. rst=1 mid-DWELL -> all outputs 0 on the next edge.
- start pulses and y_sel changes while busy -> no effect on step size, timing or sweep count.
